md_sequencer: RTL and testbench

Multi-cycle multiply/divide sequencer for the five-stage pipeline. It owns the HI/LO register pair, accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo operations from the E stage, and models the fixed arithmetic latency with a countdown state machine. It drives `busy` and a D-stage stall request, which the hazard unit ORs into its existing stall term, so that no HI/LO-touching instruction leaves D while an operation is in flight.

---
 rtl/md_pkg.sv | 31 +++
 rtl/md_sequencer_if.sv | 31 +++
 rtl/md_arith.sv | 57 +++++
 rtl/md_sequencer.sv | 119 +++++++++++
 tb/tb_md_sequencer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared op codes, default latencies and FSM encoding for the multiply/divide sequencer.
package md_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } md_state_e;

    // Ops 1..4 occupy the arithmetic unit; everything else is a register move or a no-op.
    function automatic logic md_is_start(input logic [3:0] op);
        return (op >= MD_MULT) && (op <= MD_DIVU);
    endfunction

    function automatic logic md_is_mult(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// Pipeline-facing bundle of the md sequencer; md_flush exists only when MD_FLUSH_EN is defined.
interface md_sequencer_if;
    logic [3:0]  md_op_E;
    logic [31:0] a_E;
    logic [31:0] b_E;
    logic        md_use_D;
`ifdef MD_FLUSH_EN
    logic        md_flush;
`endif
    logic        busy;
    logic        stall_md;
    logic [31:0] md_rdata_E;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output md_op_E, a_E, b_E, md_use_D,
`ifdef MD_FLUSH_EN
        output md_flush,
`endif
        input  busy, stall_md, md_rdata_E, hi, lo
    );

    modport slave (
        input  md_op_E, a_E, b_E, md_use_D,
`ifdef MD_FLUSH_EN
        input  md_flush,
`endif
        output busy, stall_md, md_rdata_E, hi, lo
    );
endinterface

// File: rtl/md_arith.sv
// Combinational signed/unsigned multiply and divide producing {hi,lo} and a divide-by-zero flag.
module md_arith
    import md_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] result_o,
    output logic        div_zero_o
);

    logic [63:0]        a_sx, b_sx, a_zx, b_zx;
    logic signed [31:0] a_s, b_s, quo_s, rem_s;
    logic [31:0]        quo_u, rem_u;
    logic               b_zero;

    assign a_sx   = {{32{a_i[31]}}, a_i};
    assign b_sx   = {{32{b_i[31]}}, b_i};
    assign a_zx   = {32'd0, a_i};
    assign b_zx   = {32'd0, b_i};
    assign a_s    = $signed(a_i);
    assign b_s    = $signed(b_i);
    assign b_zero = (b_i == 32'd0);

    // Signed / and % truncate toward zero, so the remainder follows the dividend's sign.
    always_comb begin
        quo_s = '0;
        rem_s = '0;
        quo_u = '0;
        rem_u = '0;
        if (!b_zero) begin
            quo_s = a_s / b_s;
            rem_s = a_s % b_s;
            quo_u = a_i / b_i;
            rem_u = a_i % b_i;
        end
    end

    always_comb begin
        result_o   = '0;
        div_zero_o = 1'b0;
        case (op_i)
            MD_MULT:  result_o = a_sx * b_sx;
            MD_MULTU: result_o = a_zx * b_zx;
            MD_DIV: begin
                result_o   = {rem_s, quo_s};
                div_zero_o = b_zero;
            end
            MD_DIVU: begin
                result_o   = {rem_u, quo_u};
                div_zero_o = b_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_sequencer.sv
// HI/LO owner with a countdown FSM modelling multiply/divide latency.
// Optional MD_FLUSH_EN adds md_flush to abort in-flight or arriving operations.
module md_sequencer
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input logic         clk,
    input logic         reset_n,
    md_sequencer_if.slave bus
);

    md_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic        commit_q, commit_d;

    logic [63:0] arith_res;
    logic        div_zero;
    logic        flush;
    logic        start;

    md_arith u_arith (
        .op_i       (bus.md_op_E),
        .a_i        (bus.a_E),
        .b_i        (bus.b_E),
        .result_o   (arith_res),
        .div_zero_o (div_zero)
    );

`ifdef MD_FLUSH_EN
    assign flush = bus.md_flush;
`else
    assign flush = 1'b0;
`endif

    assign start = md_is_start(bus.md_op_E);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        commit_d  = commit_q;
        unique case (state_q)
            StIdle: begin
                if (!flush) begin
                    if (start) begin
                        pend_hi_d = arith_res[63:32];
                        pend_lo_d = arith_res[31:0];
                        commit_d  = !div_zero;
                        cnt_d     = md_is_mult(bus.md_op_E) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                        state_d   = StBusy;
                    end else if (bus.md_op_E == MD_MTHI) begin
                        hi_d = bus.a_E;
                    end else if (bus.md_op_E == MD_MTLO) begin
                        lo_d = bus.a_E;
                    end
                end
            end
            StBusy: begin
                // Any op arriving here is dropped; the pipeline's stall keeps this from happening.
                if (flush) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = StIdle;
                        if (commit_q) begin
                            hi_d = pend_hi_q;
                            lo_d = pend_lo_q;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            commit_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            commit_q  <= commit_d;
        end
    end

    assign bus.busy     = (state_q == StBusy);
    assign bus.stall_md = bus.md_use_D & ((state_q == StBusy) | start);
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

    always_comb begin
        bus.md_rdata_E = '0;
        if (bus.md_op_E == MD_MFHI) begin
            bus.md_rdata_E = hi_q;
        end else if (bus.md_op_E == MD_MFLO) begin
            bus.md_rdata_E = lo_q;
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed self-checking bench for md_sequencer; flush scenario compiled in with MD_FLUSH_EN.
module tb_md_sequencer;
    import md_pkg::*;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    md_sequencer_if bus ();

    md_sequencer #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Drives one op for a cycle, then counts busy cycles (bounded at 40).
    task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int n);
        @(negedge clk);
        bus.md_op_E = op;
        bus.a_E     = a;
        bus.b_E     = b;
        @(negedge clk);
        bus.md_op_E = MD_NONE;
        n = 0;
        while (bus.busy && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", bus.busy); end
        total++; if (bus.stall_md !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b want=0", bus.stall_md); end
        total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h want=0", bus.hi); end
        total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h want=0", bus.lo); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult();
        int n;
        start_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, n);
        total++; if (n !== 5) begin bad++; $display("FAIL mult_cycles got=%0d want=5", n); end
        total++; if (bus.hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h want=ffffffff", bus.hi); end
        total++; if (bus.lo !== 32'hFFFF_FFFA) begin bad++; $display("FAIL mult_lo got=%h want=fffffffa", bus.lo); end
        start_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, n);
        total++; if (n !== 5) begin bad++; $display("FAIL multu_cycles got=%0d want=5", n); end
        total++; if (bus.hi !== 32'h2) begin bad++; $display("FAIL multu_hi got=%h want=2", bus.hi); end
        total++; if (bus.lo !== 32'hFFFF_FFFA) begin bad++; $display("FAIL multu_lo got=%h want=fffffffa", bus.lo); end
    endtask

    task automatic test_div();
        int n;
        start_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, n);
        total++; if (n !== 10) begin bad++; $display("FAIL div_cycles got=%0d want=10", n); end
        total++; if (bus.lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo got=%h want=fffffffd", bus.lo); end
        total++; if (bus.hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi got=%h want=ffffffff", bus.hi); end
        start_op(MD_DIV, 32'd7, 32'hFFFF_FFFE, n);
        total++; if (bus.lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_neg_lo got=%h want=fffffffd", bus.lo); end
        total++; if (bus.hi !== 32'h1) begin bad++; $display("FAIL div_neg_hi got=%h want=1", bus.hi); end
        start_op(MD_DIVU, 32'd100, 32'd7, n);
        total++; if (bus.lo !== 32'd14) begin bad++; $display("FAIL divu_lo got=%h want=e", bus.lo); end
        total++; if (bus.hi !== 32'd2) begin bad++; $display("FAIL divu_hi got=%h want=2", bus.hi); end
        start_op(MD_DIVU, 32'd7, 32'd0, n);
        total++; if (n !== 10) begin bad++; $display("FAIL divz_cycles got=%0d want=10", n); end
        total++; if (bus.lo !== 32'd14) begin bad++; $display("FAIL divz_lo got=%h want=e", bus.lo); end
        total++; if (bus.hi !== 32'd2) begin bad++; $display("FAIL divz_hi got=%h want=2", bus.hi); end
    endtask

    task automatic test_stall();
        int n;
        @(negedge clk);
        bus.md_op_E  = MD_MULT;
        bus.a_E      = 32'd5;
        bus.b_E      = 32'd6;
        bus.md_use_D = 1'b1;
        #1;
        total++; if (bus.stall_md !== 1'b1) begin bad++; $display("FAIL stall_start got=%0b want=1", bus.stall_md); end
        @(negedge clk);
        bus.md_op_E = MD_NONE;
        n = 0;
        while (bus.stall_md && n < 40) begin
            n++;
            @(negedge clk);
        end
        total++; if (n !== 5) begin bad++; $display("FAIL stall_busy_cycles got=%0d want=5", n); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL stall_end_busy got=%0b want=0", bus.busy); end
        bus.md_use_D = 1'b0;
        bus.md_op_E  = MD_MFLO;
        #1;
        total++; if (bus.md_rdata_E !== 32'd30) begin bad++; $display("FAIL stall_mflo got=%h want=1e", bus.md_rdata_E); end
        bus.md_op_E = MD_MFHI;
        #1;
        total++; if (bus.md_rdata_E !== 32'd0) begin bad++; $display("FAIL stall_mfhi got=%h want=0", bus.md_rdata_E); end
        bus.md_op_E = MD_NONE;
    endtask

    task automatic test_move();
        @(negedge clk);
        bus.md_op_E = MD_MTHI;
        bus.a_E     = 32'h1234_5678;
        @(negedge clk);
        bus.md_op_E = MD_MFHI;
        #1;
        total++; if (bus.md_rdata_E !== 32'h1234_5678) begin bad++; $display("FAIL mthi_mfhi got=%h want=12345678", bus.md_rdata_E); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mthi_busy got=%0b want=0", bus.busy); end
        @(negedge clk);
        bus.md_op_E = MD_MTLO;
        bus.a_E     = 32'hCAFE_F00D;
        @(negedge clk);
        bus.md_op_E = MD_MFLO;
        #1;
        total++; if (bus.md_rdata_E !== 32'hCAFE_F00D) begin bad++; $display("FAIL mtlo_mflo got=%h want=cafef00d", bus.md_rdata_E); end
        bus.md_op_E = 4'd9;
        #1;
        total++; if (bus.md_rdata_E !== 32'h0) begin bad++; $display("FAIL op9_rdata got=%h want=0", bus.md_rdata_E); end
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL op9_busy got=%0b want=0", bus.busy); end
        bus.md_op_E = MD_NONE;
    endtask

    task automatic test_busy_ignore();
        int n;
        @(negedge clk);
        bus.md_op_E = MD_MULT;
        bus.a_E     = 32'd2;
        bus.b_E     = 32'd3;
        @(negedge clk);
        bus.md_op_E = MD_MTHI;
        bus.a_E     = 32'hFFFF_0000;
        @(negedge clk);
        bus.md_op_E = MD_DIV;
        bus.a_E     = 32'd9;
        bus.b_E     = 32'd2;
        @(negedge clk);
        bus.md_op_E = MD_NONE;
        n = 0;
        while (bus.busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        total++; if (n !== 3) begin bad++; $display("FAIL ignore_remaining got=%0d want=3", n); end
        total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL ignore_hi got=%h want=0", bus.hi); end
        total++; if (bus.lo !== 32'd6) begin bad++; $display("FAIL ignore_lo got=%h want=6", bus.lo); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.md_op_E = MD_DIV;
        bus.a_E     = 32'd100;
        bus.b_E     = 32'd3;
        @(negedge clk);
        bus.md_op_E = MD_NONE;
        idle_cycles(2);
        reset_n = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%0b want=0", bus.busy); end
        total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL rst_mid_hi got=%h want=0", bus.hi); end
        total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL rst_mid_lo got=%h want=0", bus.lo); end
        @(negedge clk);
        reset_n = 1'b1;
        idle_cycles(15);
        total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL rst_nocommit_lo got=%h want=0", bus.lo); end
        total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL rst_nocommit_hi got=%h want=0", bus.hi); end
    endtask

`ifdef MD_FLUSH_EN
    task automatic test_flush();
        @(negedge clk);
        bus.md_op_E = MD_MTHI;
        bus.a_E     = 32'h11;
        @(negedge clk);
        bus.md_op_E = MD_MTLO;
        bus.a_E     = 32'h22;
        @(negedge clk);
        bus.md_op_E = MD_MULT;
        bus.a_E     = 32'd3;
        bus.b_E     = 32'd4;
        @(negedge clk);
        bus.md_op_E = MD_NONE;
        @(negedge clk);
        bus.md_flush = 1'b1;
        @(negedge clk);
        bus.md_flush = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%0b want=0", bus.busy); end
        idle_cycles(10);
        total++; if (bus.hi !== 32'h11) begin bad++; $display("FAIL flush_hi got=%h want=11", bus.hi); end
        total++; if (bus.lo !== 32'h22) begin bad++; $display("FAIL flush_lo got=%h want=22", bus.lo); end
        bus.md_op_E  = MD_MTLO;
        bus.a_E      = 32'h99;
        bus.md_flush = 1'b1;
        @(negedge clk);
        bus.md_op_E = MD_MULT;
        @(negedge clk);
        bus.md_op_E  = MD_NONE;
        bus.md_flush = 1'b0;
        total++; if (bus.lo !== 32'h22) begin bad++; $display("FAIL flush_mtlo got=%h want=22", bus.lo); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_start got=%0b want=0", bus.busy); end
    endtask
`endif

    initial begin
        total        = 0;
        bad          = 0;
        reset_n      = 1'b0;
        bus.md_op_E  = MD_NONE;
        bus.a_E      = '0;
        bus.b_E      = '0;
        bus.md_use_D = 1'b0;
`ifdef MD_FLUSH_EN
        bus.md_flush = 1'b0;
`endif
        test_reset();
        test_mult();
        test_div();
        test_stall();
        test_move();
        test_busy_ignore();
        test_reset_mid();
`ifdef MD_FLUSH_EN
        test_flush();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
